// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode and FSM encodings plus
// small classification helpers used by the control path.
// Optional multiplier controlled by macro SEQ_ALU_MUL_EN.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD        = 4'd0,
    ADDC       = 4'd1,
    SUB        = 4'd2,
    SUBC       = 4'd3,
    AND        = 4'd4,
    OR         = 4'd5,
    XOR        = 4'd6,
    NAND       = 4'd7,
    ADD_SIGNED = 4'd8,
    SHL        = 4'd9,
    SHR        = 4'd10,
    ROL        = 4'd11,
    ROR        = 4'd12,
    MUL        = 4'd13
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_shift(opcode_e op);
    return (op == SHL) || (op == SHR) || (op == ROL) || (op == ROR);
  endfunction

  // Ops that need the iterative datapath. A zero shift finishes in one cycle.
  function automatic logic is_multicycle(opcode_e op, logic shamt_nz);
`ifdef SEQ_ALU_MUL_EN
    if (op == MUL) return 1'b1;
`endif
    return is_shift(op) && shamt_nz;
  endfunction

  // Ops whose carry/borrow result is written back into c_flag.
  function automatic logic updates_cflag(opcode_e op);
`ifdef SEQ_ALU_MUL_EN
    if (op == MUL) return 1'b1;
`endif
    return (op == ADD) || (op == ADDC) || (op == SUB) || (op == SUBC) ||
           (op == SHL) || (op == SHR);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath for shifts/rotates (one bit per step) and, when
// SEQ_ALU_MUL_EN is defined, a shift-add multiplier (one partial product per
// step). Exposes next-state result so the caller can register the final step.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  opcode_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   shamt_i,
`ifdef SEQ_ALU_MUL_EN
  input  logic [WIDTH-1:0] b_i,
`endif
  output logic             last_o,
  output logic [WIDTH-1:0] res_d_o,
  output logic             cout_d_o
);

  localparam int CW = $clog2(WIDTH + 1);

  opcode_e          op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SEQ_ALU_MUL_EN
  // acc holds the low product half (multiplier bits shift out of it).
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   sum;
`endif

  // Load operands on start, otherwise advance one step per EXEC cycle.
  always_comb begin
    op_d   = op_q;
    acc_d  = acc_q;
    cout_d = cout_q;
    cnt_d  = cnt_q;
`ifdef SEQ_ALU_MUL_EN
    hi_d    = hi_q;
    mcand_d = mcand_q;
    sum     = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`endif
    if (start_i) begin
      op_d   = op_i;
      acc_d  = a_i;
      cout_d = 1'b0;
      cnt_d  = CW'(shamt_i);
`ifdef SEQ_ALU_MUL_EN
      hi_d    = '0;
      mcand_d = a_i;
      if (op_i == MUL) begin
        acc_d = b_i;
        cnt_d = CW'(WIDTH);
      end
`endif
    end else if (step_i) begin
      cnt_d = cnt_q - CW'(1);
      case (op_q)
        SHL: begin
          cout_d = acc_q[WIDTH-1];
          acc_d  = {acc_q[WIDTH-2:0], 1'b0};
        end
        SHR: begin
          cout_d = acc_q[0];
          acc_d  = {1'b0, acc_q[WIDTH-1:1]};
        end
        ROL: begin
          cout_d = 1'b0;
          acc_d  = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
        end
        ROR: begin
          cout_d = 1'b0;
          acc_d  = {acc_q[0], acc_q[WIDTH-1:1]};
        end
`ifdef SEQ_ALU_MUL_EN
        MUL: begin
          hi_d   = sum[WIDTH:1];
          acc_d  = {sum[0], acc_q[WIDTH-1:1]};
          cout_d = |sum[WIDTH:1];
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath and step counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= ADD;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SEQ_ALU_MUL_EN
      hi_q    <= '0;
      mcand_q <= '0;
`endif
    end else begin
      op_q    <= op_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_ALU_MUL_EN
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
`endif
    end
  end

  assign last_o   = step_i && (cnt_q == CW'(1));
  assign res_d_o  = acc_d;
  assign cout_d_o = cout_d;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake. Single-cycle ops are computed
// here and registered on acceptance; shifts, rotates and (with macro
// SEQ_ALU_MUL_EN) MUL run in seq_alu_iter. Result and flags are held in DONE
// until the consumer accepts them.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             cout,
  output logic             Z,
  output logic             N,
  output logic             c_flag
);

  state_e           state_q, state_d;
  opcode_e          op_in, op_q;
  logic [SHW-1:0]   shamt;
  logic             start, load_single, load_iter;
  logic [WIDTH-1:0] sc_res, iter_res, fin_res, mag;
  logic             sc_cout, iter_cout, iter_last, fin_cout;
  opcode_e          fin_op;
  logic [WIDTH-1:0] alu_out_q;
  logic             cout_q, z_q, n_q, c_flag_q;

  assign op_in = opcode_e'(opcode);
  assign shamt = alu_in2[SHW-1:0];

  // Single-cycle results, evaluated from the live request in IDLE.
  always_comb begin
    sc_res  = '0;
    sc_cout = 1'b0;
    mag     = '0;
    case (op_in)
      ADD:  {sc_cout, sc_res} = {1'b0, alu_in1} + {1'b0, alu_in2};
      ADDC: {sc_cout, sc_res} = {1'b0, alu_in1} + {1'b0, alu_in2} + (WIDTH+1)'(c_flag_q);
      SUB:  {sc_cout, sc_res} = {1'b0, alu_in1} - {1'b0, alu_in2};
      SUBC: {sc_cout, sc_res} = {1'b0, alu_in1} - {1'b0, alu_in2} - (WIDTH+1)'(c_flag_q);
      AND:  sc_res = alu_in1 & alu_in2;
      OR:   sc_res = alu_in1 | alu_in2;
      XOR:  sc_res = alu_in1 ^ alu_in2;
      NAND: sc_res = ~(alu_in1 & alu_in2);
      ADD_SIGNED: begin
        // in2 is sign-magnitude: top bit selects subtract.
        mag    = {1'b0, alu_in2[WIDTH-2:0]};
        sc_res = alu_in2[WIDTH-1] ? (alu_in1 - mag) : (alu_in1 + mag);
      end
      // Only reached here with a zero shift amount.
      SHL, SHR, ROL, ROR: sc_res = alu_in1;
      default: ;
    endcase
  end

  // Next-state logic and datapath load strobes.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    load_single = 1'b0;
    load_iter   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_multicycle(op_in, |shamt)) begin
            start   = 1'b1;
            state_d = EXEC;
          end else begin
            load_single = 1'b1;
            state_d     = DONE;
          end
        end
      end
      EXEC: begin
        if (iter_last) begin
          load_iter = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Opcode capture so the flag update on iterative completion knows its op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     op_q <= ADD;
    else if (start) op_q <= op_in;
  end

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .step_i   (state_q == EXEC),
    .op_i     (op_in),
    .a_i      (alu_in1),
    .shamt_i  (shamt),
`ifdef SEQ_ALU_MUL_EN
    .b_i      (alu_in2),
`endif
    .last_o   (iter_last),
    .res_d_o  (iter_res),
    .cout_d_o (iter_cout)
  );

  assign fin_res  = load_single ? sc_res  : iter_res;
  assign fin_cout = load_single ? sc_cout : iter_cout;
  assign fin_op   = load_single ? op_in   : op_q;

  // Result and flag registers, written once on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      cout_q    <= 1'b0;
      z_q       <= 1'b1;
      n_q       <= 1'b0;
      c_flag_q  <= 1'b0;
    end else if (load_single || load_iter) begin
      alu_out_q <= fin_res;
      cout_q    <= fin_cout;
      z_q       <= (fin_res == '0);
      n_q       <= fin_res[WIDTH-1];
      if (updates_cflag(fin_op)) c_flag_q <= fin_cout;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign alu_out   = alu_out_q;
  assign cout      = cout_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign c_flag    = c_flag_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8; MUL expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] opcode;
  logic [7:0] alu_in1, alu_in2, alu_out;
  logic       cout, Z, N, c_flag;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .cout      (cout),
    .Z         (Z),
    .N         (N),
    .c_flag    (c_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, count cycles spent after the accept edge until
  // out_valid, then check result and flags. Leaves the result unconsumed.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int exp_cyc, input logic [7:0] exp_res,
                        input logic exp_c, input logic exp_cf);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = op; alu_in1 = a; alu_in2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = 4'd0; alu_in1 = ~a; alu_in2 = ~b;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, ".alu_out"}, 32'(alu_out), 32'(exp_res));
    chk({tag, ".cout"}, 32'(cout), 32'(exp_c));
    chk({tag, ".Z"}, 32'(Z), 32'(exp_res == 8'h00));
    chk({tag, ".N"}, 32'(N), 32'(exp_res[7]));
    chk({tag, ".c_flag"}, 32'(c_flag), 32'(exp_cf));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".rel_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".rel_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 4'd0; alu_in1 = 8'h00; alu_in2 = 8'h00;
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.alu_out", 32'(alu_out), 32'h00);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.Z", 32'(Z), 32'd1);
    chk("rst.N", 32'(N), 32'd0);
    chk("rst.c_flag", 32'(c_flag), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Arithmetic with carry chaining through c_flag.
    run_op("add",   4'd0, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1); release_out("add");
    run_op("addc",  4'd1, 8'h10, 8'h20, 0, 8'h31, 1'b0, 1'b0); release_out("addc");
    run_op("sub",   4'd2, 8'h05, 8'h07, 0, 8'hFE, 1'b1, 1'b1); release_out("sub");
    run_op("adds",  4'd8, 8'h10, 8'h83, 0, 8'h0D, 1'b0, 1'b1); release_out("adds");
    run_op("subc",  4'd3, 8'h10, 8'h01, 0, 8'h0E, 1'b0, 1'b0); release_out("subc");
    // Bitwise.
    run_op("and",   4'd4, 8'hF0, 8'h3C, 0, 8'h30, 1'b0, 1'b0); release_out("and");
    run_op("or",    4'd5, 8'hF0, 8'h0F, 0, 8'hFF, 1'b0, 1'b0); release_out("or");
    run_op("xor",   4'd6, 8'hAA, 8'hAA, 0, 8'h00, 1'b0, 1'b0); release_out("xor");
    run_op("nand",  4'd7, 8'hFF, 8'h0F, 0, 8'hF0, 1'b0, 1'b0); release_out("nand");
    // Shifts and rotates.
    run_op("shl3",  4'd9,  8'h81, 8'h03, 3, 8'h08, 1'b0, 1'b0); release_out("shl3");
    run_op("shl1",  4'd9,  8'h81, 8'h01, 1, 8'h02, 1'b1, 1'b1); release_out("shl1");
    run_op("ror1",  4'd12, 8'h01, 8'h01, 1, 8'h80, 1'b0, 1'b1); release_out("ror1");
    run_op("shr0",  4'd10, 8'h81, 8'h08, 0, 8'h81, 1'b0, 1'b0); release_out("shr0");
    run_op("rol4",  4'd11, 8'h81, 8'h04, 4, 8'h18, 1'b0, 1'b0); release_out("rol4");
    run_op("shr1",  4'd10, 8'h81, 8'h01, 1, 8'h40, 1'b1, 1'b1); release_out("shr1");
    // Undefined opcode leaves c_flag alone.
    run_op("undef", 4'd15, 8'h12, 8'h34, 0, 8'h00, 1'b0, 1'b1); release_out("undef");
`ifdef SEQ_ALU_MUL_EN
    run_op("mul",   4'd13, 8'h10, 8'h11, 8, 8'h10, 1'b1, 1'b1); release_out("mul");
`else
    run_op("mul",   4'd13, 8'h10, 8'h11, 0, 8'h00, 1'b0, 1'b1); release_out("mul");
`endif

    // Backpressure: result held, new requests ignored while in DONE.
    run_op("hold", 4'd6, 8'h5A, 8'h0F, 0, 8'h55, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opcode = 4'd0; alu_in1 = 8'h01; alu_in2 = 8'h01;
      @(posedge clk); #1;
      chk("hold.valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk("hold.alu_out", 32'(alu_out), 32'h55);
      chk("hold.c_flag", 32'(c_flag), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold.rel_ready", 32'(in_ready), 32'd1);
    chk("hold.rel_valid", 32'(out_valid), 32'd0);
    chk("hold.rel_out", 32'(alu_out), 32'h55);

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd9; alu_in1 = 8'hFF; alu_in2 = 8'h07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.in_ready", 32'(in_ready), 32'd1);
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.alu_out", 32'(alu_out), 32'h00);
    chk("mrst.Z", 32'(Z), 32'd1);
    chk("mrst.c_flag", 32'(c_flag), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst.no_valid", 32'(seen), 32'd0);
    chk("mrst.idle", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; legal range 4..32.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width derived from WIDTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 opcode  input  4  operation select; encodings from alu_pkg.
REQ-008 alu_in1, alu_in2  input  WIDTH  operands.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 alu_out  output  WIDTH  registered result.
REQ-012 cout, Z, N  output  1 each  registered carry/borrow, zero, sign (alu_out[WIDTH-1]) of the held result.
REQ-013 c_flag  output  1  carry flag consumed by ADDC/SUBC.

Function
REQ-014 FSM states: IDLE, EXEC, DONE. in_ready = (state==IDLE).
REQ-015 IDLE with in_valid: operands and opcode captured. Single-cycle ops go to DONE next edge. Shift/rotate ops with shamt != 0, and MUL, go to EXEC.
REQ-016 EXEC: one step per cycle; counter counts down from shamt (shifts) or WIDTH (MUL); counter 1 -> DONE.
REQ-017 DONE: out_valid=1; alu_out/cout/Z/N stable until out_valid && out_ready, then IDLE. No new request is accepted in the same cycle.
REQ-018 Latency from accept to out_valid: 1 cycle for single-cycle ops, shamt cycles for shifts with shamt >= 1, WIDTH cycles for MUL.
REQ-019 ADD / ADDC: {cout,alu_out} = in1+in2 (+c_flag for ADDC), computed at WIDTH+1 bits.
REQ-020 SUB / SUBC: {cout,alu_out} = in1-in2 (-c_flag for SUBC), computed at WIDTH+1 bits; cout=1 indicates borrow.
REQ-021 AND, OR, XOR, NAND: bitwise; cout=0.
REQ-022 ADD_SIGNED: in2 is sign-magnitude. The magnitude is {1'b0,in2[WIDTH-2:0]}, added if in2[WIDTH-1]=0 and subtracted otherwise; cout=0; the result wraps mod 2^WIDTH.
REQ-023 SHL, SHR, ROL, ROR: shamt = in2[SHW-1:0].
REQ-024 Shifts move one bit per EXEC cycle; shamt=0 returns in1 unchanged in 1 cycle.
REQ-025 For SHL/SHR, cout is the last bit shifted out (0 if shamt=0). For ROL/ROR, cout=0.
REQ-026 c_flag is updated to cout on entry to DONE for ADD, ADDC, SUB, SUBC, SHL, SHR and MUL; all other ops leave it unchanged.
REQ-027 Undefined opcodes complete in 1 cycle with alu_out=0, cout=0, Z=1; c_flag is unchanged.
REQ-028 in_valid is ignored outside IDLE; captured operands are not affected by input changes after acceptance.

Reset
REQ-029 rst_n low forces asynchronously: state=IDLE, alu_out=0, cout=0, Z=1, N=0, c_flag=0, out_valid=0, counter=0. in_ready=1 at the first edge after release.
REQ-030 Reset during EXEC or DONE discards the operation; no out_valid is produced for it.

Configuration
REQ-031 Macro SEQ_ALU_MUL_EN defined: MUL performs shift-add over WIDTH cycles. alu_out is the low WIDTH bits of the unsigned product; cout=1 if any high product bit is nonzero.
REQ-032 Macro SEQ_ALU_MUL_EN undefined: the MUL opcode is treated as undefined (REQ-027); no multiplier state is synthesised.

Structure
REQ-033 Package alu_pkg holds: the opcode enum (ADD=0, ADDC=1, SUB=2, SUBC=3, AND=4, OR=5, XOR=6, NAND=7, ADD_SIGNED=8, SHL=9, SHR=10, ROL=11, ROR=12, MUL=13), the state enum, and an is_multicycle() function.
REQ-034 Sub-module seq_alu_iter holds the iterative shift/rotate/multiply datapath and counter. seq_alu holds the FSM, the combinational single-cycle ops, flag registers and the handshake.

Verification
REQ-035 WIDTH=8, ADD 0xFF+0x01 -> 1 cycle later alu_out=0x00, cout=1, Z=1, c_flag=1; a following ADDC 0x10+0x20 -> 0x31.
REQ-036 SUB 0x05-0x07 -> alu_out=0xFE, cout=1, N=1; ADD_SIGNED 0x10,0x83 -> 0x0D, cout=0.
REQ-037 SHL 0x81 by 3 -> out_valid after exactly 3 cycles, alu_out=0x08, cout=0; ROR 0x01 by 1 -> 0x80; SHR shamt 0 -> 1 cycle, 0x81 unchanged.
REQ-038 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0 and in_valid ignored throughout; out_ready=1 -> IDLE next edge.
REQ-039 SEQ_ALU_MUL_EN defined, MUL 0x10*0x11 -> out_valid after 8 cycles, alu_out=0x10, cout=1. Undefined: -> 1 cycle, alu_out=0, Z=1.
REQ-040 rst_n pulsed low mid-EXEC of SHL by 7 -> immediate IDLE, all outputs at reset values, no out_valid afterwards.
